// File: rtl/riscv_pkg.sv
// riscv_pkg: types and constants shared by the RV32I fetch stage.
// The fetch entry layout is {word, pc, fault}, with the fault bit in the LSB.
package riscv_pkg;

  localparam int          INS_BYTES = 4;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
    logic        fault;
  } fetch_entry_t;

endpackage

// File: rtl/riscv_fetch_fifo.sv
// riscv_fetch_fifo: power-of-two circular buffer holding fetched entries in order.
// Flush empties the buffer and takes priority over push and pop.
module riscv_fetch_fifo
  import riscv_pkg::*;
#(
  parameter int Depth = 4,
  parameter int Width = 65
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [Width-1:0]       push_data,
  input  logic                   pop,
  output logic [Width-1:0]       head_data,
  output logic [$clog2(Depth):0] count
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  head;
  logic [PtrW-1:0]  tail;

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < Depth; i++) mem[i] <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= push_data;
        tail      <= tail + PtrW'(1);
      end
      if (pop) head <= head + PtrW'(1);
      count <= count + CntW'(push) - CntW'(pop);
    end
  end

  assign head_data = mem[head];

endmodule

// File: rtl/riscv_fetch_queue.sv
// riscv_fetch_queue: RV32I fetch stage with an in-order instruction queue and redirect flush.
// Optional macro FETCH_ALIGN_CHECK_EN turns misaligned redirects into a fault entry and halts fetch.
module riscv_fetch_queue
  import riscv_pkg::*;
#(
  parameter int               dataW   = 32,
  parameter int               AddrW   = 32,
  parameter int               Depth   = 4,
  parameter logic [AddrW-1:0] ResetPC = AddrW'(RESET_PC)
) (
  input  logic             clock,
  input  logic             reset,
  output logic             RomReq,
  output logic [AddrW-1:0] RomAddr,
  input  logic             RomGnt,
  input  logic             RomRValid,
  input  logic [dataW-1:0] RomRData,
  output logic             InsValid,
  input  logic             InsReady,
  output logic [dataW-1:0] InsWord,
  output logic [AddrW-1:0] InsPC,
  output logic             InsFault,
  input  logic             Redirect,
  input  logic [AddrW-1:0] RedirectPC
);

  localparam int               CntW   = $clog2(Depth) + 1;
  localparam int               EntW   = dataW + AddrW + 1;
  localparam logic [AddrW-1:0] StepPC = AddrW'(INS_BYTES);

  logic [AddrW-1:0] fetch_pc;
  logic [AddrW-1:0] issue_pc;
  logic [AddrW-1:0] target_pc;
  logic [AddrW-1:0] fault_pc;
  logic [CntW-1:0]  count;
  logic [CntW-1:0]  outstanding;
  logic [CntW-1:0]  drop_cnt;
  logic [CntW:0]    in_use;
  logic             halted;
  logic             fault_push;
  logic             grant;
  logic             keep_rsp;
  logic             push;
  logic             pop;
  logic [EntW-1:0]  push_data;
  logic [EntW-1:0]  head_data;

  // Queue slots are reserved at issue time, so responses never need backpressure.
  assign target_pc = {RedirectPC[AddrW-1:2], 2'b00};
  assign in_use    = {1'b0, count} + {1'b0, outstanding};
  assign RomReq    = !reset && !Redirect && !halted && (in_use < (CntW+1)'(Depth));
  assign RomAddr   = fetch_pc;
  assign grant     = RomReq && RomGnt;
  assign keep_rsp  = RomRValid && (drop_cnt == '0) && !Redirect;
  assign push      = keep_rsp || (fault_push && !Redirect);
  assign pop       = InsValid && InsReady && !Redirect;
  assign push_data = fault_push ? {{dataW{1'b0}}, fault_pc, 1'b1}
                                : {RomRData, issue_pc, 1'b0};

  assign InsValid = (count != '0);
  assign InsWord  = head_data[EntW-1 -: dataW];
  assign InsPC    = head_data[AddrW:1];

  // issue_pc is the PC of the next kept response; every stale response is covered by drop_cnt.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc    <= ResetPC;
      issue_pc    <= ResetPC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CntW'(grant) - CntW'(RomRValid);
      if (Redirect) begin
        fetch_pc <= target_pc;
        issue_pc <= target_pc;
        drop_cnt <= outstanding - CntW'(RomRValid);
      end else begin
        if (grant)    fetch_pc <= fetch_pc + StepPC;
        if (keep_rsp) issue_pc <= issue_pc + StepPC;
        if (RomRValid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CntW'(1);
      end
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  // The fault entry is pushed the cycle after the flush, into an empty queue.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      halted     <= 1'b0;
      fault_push <= 1'b0;
      fault_pc   <= '0;
    end else if (Redirect) begin
      halted     <= (RedirectPC[1:0] != 2'b00);
      fault_push <= (RedirectPC[1:0] != 2'b00);
      fault_pc   <= RedirectPC;
    end else begin
      fault_push <= 1'b0;
    end
  end

  assign InsFault = head_data[0];
`else
  logic [1:0] unused_pc_lsb;
  logic       unused_fault;

  assign halted        = 1'b0;
  assign fault_push    = 1'b0;
  assign fault_pc      = '0;
  assign unused_pc_lsb = RedirectPC[1:0];
  assign unused_fault  = head_data[0];
  assign InsFault      = 1'b0;
`endif

  riscv_fetch_fifo #(
    .Depth (Depth),
    .Width (EntW)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (Redirect),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head_data),
    .count     (count)
  );

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// tb_riscv_fetch_queue: directed bench for the fetch queue with an in-order ROM model of selectable latency.
// Align-check expectations follow FETCH_ALIGN_CHECK_EN, in step with the RTL build.
module tb_riscv_fetch_queue;

  logic        clock;
  logic        reset;
  logic        RomReq;
  logic [31:0] RomAddr;
  logic        RomGnt;
  logic        RomRValid;
  logic [31:0] RomRData;
  logic        InsValid;
  logic        InsReady;
  logic [31:0] InsWord;
  logic [31:0] InsPC;
  logic        InsFault;
  logic        Redirect;
  logic [31:0] RedirectPC;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } romRsp_t;

  romRsp_t romQ[$];
  int      total;
  int      bad;
  int      cyc;
  int      lat;
  int      grantCnt;
  int      grantMark;

  riscv_fetch_queue dut (
    .clock      (clock),
    .reset      (reset),
    .RomReq     (RomReq),
    .RomAddr    (RomAddr),
    .RomGnt     (RomGnt),
    .RomRValid  (RomRValid),
    .RomRData   (RomRData),
    .InsValid   (InsValid),
    .InsReady   (InsReady),
    .InsWord    (InsWord),
    .InsPC      (InsPC),
    .InsFault   (InsFault),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] romWord(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance one clock; the ROM model answers grants in order, lat cycles after the granting edge.
  task automatic tick();
    logic        iss;
    logic [31:0] a;
    logic        cons;
    iss  = RomReq && RomGnt;
    a    = RomAddr;
    cons = RomRValid;
    @(posedge clock);
    #1;
    cyc++;
    if (cons && romQ.size() > 0) void'(romQ.pop_front());
    if (iss) begin
      romQ.push_back('{addr: a, due: cyc + lat - 1});
      grantCnt++;
    end
    if (romQ.size() > 0 && romQ[0].due <= cyc) begin
      RomRValid = 1'b1;
      RomRData  = romWord(romQ[0].addr);
    end else begin
      RomRValid = 1'b0;
      RomRData  = '0;
    end
  endtask

  task automatic applyStimulus(input logic ready, input logic redir, input logic [31:0] rpc);
    tick();
    InsReady   = ready;
    Redirect   = redir;
    RedirectPC = rpc;
    #1;
  endtask

  task automatic doReset(input int latency);
    reset      = 1'b1;
    Redirect   = 1'b0;
    RedirectPC = '0;
    InsReady   = 1'b0;
    RomRValid  = 1'b0;
    RomRData   = '0;
    romQ.delete();
    lat = latency;
    #1;
    checkOutput("mid reset InsValid", 32'(InsValid), 32'd0);
    checkOutput("mid reset RomReq", 32'(RomReq), 32'd0);
    @(posedge clock);
    #1;
    reset    = 1'b0;
    cyc      = 0;
    grantCnt = 0;
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total      = 0;
    bad        = 0;
    cyc        = 0;
    lat        = 1;
    grantCnt   = 0;
    grantMark  = 0;
    reset      = 1'b0;
    RomGnt     = 1'b1;
    RomRValid  = 1'b0;
    RomRData   = '0;
    InsReady   = 1'b0;
    Redirect   = 1'b0;
    RedirectPC = '0;

    #1 reset = 1'b1;
    #1;
    checkOutput("reset RomReq", 32'(RomReq), 32'd0);
    checkOutput("reset RomAddr", RomAddr, 32'h0);
    checkOutput("reset InsValid", 32'(InsValid), 32'd0);
    checkOutput("reset InsWord", InsWord, 32'h0);
    checkOutput("reset InsPC", InsPC, 32'h0);
    checkOutput("reset InsFault", 32'(InsFault), 32'd0);

    $display("[TB] streaming with 1-cycle ROM");
    @(posedge clock);
    #1;
    reset    = 1'b0;
    InsReady = 1'b1;
    #1;
    checkOutput("c0 RomReq", 32'(RomReq), 32'd1);
    checkOutput("c0 RomAddr", RomAddr, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("c1 RomAddr", RomAddr, 32'h4);
    checkOutput("c1 InsValid", 32'(InsValid), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("c2 RomAddr", RomAddr, 32'h8);
    checkOutput("c2 InsValid", 32'(InsValid), 32'd1);
    checkOutput("c2 InsPC", InsPC, 32'h0);
    checkOutput("c2 InsWord", InsWord, 32'h5A5A_0000);

    $display("[TB] redirect together with response and pop");
    applyStimulus(1'b1, 1'b1, 32'h100);
    checkOutput("c3 InsPC", InsPC, 32'h4);
    checkOutput("c3 InsWord", InsWord, 32'h5A5A_0004);
    checkOutput("c3 RomReq under redirect", 32'(RomReq), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("c4 RomReq", 32'(RomReq), 32'd1);
    checkOutput("c4 RomAddr", RomAddr, 32'h100);
    checkOutput("c4 InsValid", 32'(InsValid), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("c5 InsValid", 32'(InsValid), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("c6 InsValid", 32'(InsValid), 32'd1);
    checkOutput("c6 InsPC", InsPC, 32'h100);
    checkOutput("c6 InsWord", InsWord, 32'h5A5A_0100);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("c7 InsPC", InsPC, 32'h104);

    $display("[TB] address wrap");
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("wrap RomAddr top", RomAddr, 32'hFFFF_FFFC);
    checkOutput("wrap RomReq", 32'(RomReq), 32'd1);
    checkOutput("wrap InsValid flushed", 32'(InsValid), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("wrap RomAddr zero", RomAddr, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("wrap InsPC top", InsPC, 32'hFFFF_FFFC);
    checkOutput("wrap InsWord top", InsWord, 32'hA5A5_FFFC);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("wrap InsPC zero", InsPC, 32'h0);
    checkOutput("wrap InsWord zero", InsWord, 32'h5A5A_0000);

    $display("[TB] misaligned redirect");
    applyStimulus(1'b1, 1'b1, 32'h102);
    applyStimulus(1'b1, 1'b0, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    checkOutput("align RomReq halted", 32'(RomReq), 32'd0);
    checkOutput("align InsValid flushed", 32'(InsValid), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("align fault InsValid", 32'(InsValid), 32'd1);
    checkOutput("align fault InsFault", 32'(InsFault), 32'd1);
    checkOutput("align fault InsPC", InsPC, 32'h102);
    checkOutput("align fault InsWord", InsWord, 32'h0);
    grantMark = grantCnt;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("align single entry", 32'(InsValid), 32'd0);
    checkOutput("align no grants while halted", grantCnt - grantMark, 32'd0);
    checkOutput("align RomReq still halted", 32'(RomReq), 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h200);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("align resume RomReq", 32'(RomReq), 32'd1);
    checkOutput("align resume RomAddr", RomAddr, 32'h200);
`else
    checkOutput("align RomReq", 32'(RomReq), 32'd1);
    checkOutput("align RomAddr forced", RomAddr, 32'h100);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("align InsValid", 32'(InsValid), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("align InsValid resumed", 32'(InsValid), 32'd1);
    checkOutput("align InsPC", InsPC, 32'h100);
    checkOutput("align InsFault", 32'(InsFault), 32'd0);
    checkOutput("align InsWord", InsWord, 32'h5A5A_0100);
`endif

    $display("[TB] decode stall fills the queue");
    doReset(1);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("stall grant count", grantCnt, 32'd4);
    checkOutput("stall RomReq", 32'(RomReq), 32'd0);
    checkOutput("stall InsValid", 32'(InsValid), 32'd1);
    checkOutput("stall head PC", InsPC, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("drain PC0", InsPC, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("drain PC4", InsPC, 32'h4);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("drain PC8", InsPC, 32'h8);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("drain PCC", InsPC, 32'hC);
    checkOutput("drain WordC", InsWord, 32'h5A5A_000C);
    checkOutput("drain InsValid", 32'(InsValid), 32'd1);

    $display("[TB] redirect with two responses in flight, ROM latency 3");
    doReset(3);
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h100);
    checkOutput("lat3 RomReq under redirect", 32'(RomReq), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("lat3 RomAddr", RomAddr, 32'h100);
    checkOutput("lat3 InsValid", 32'(InsValid), 32'd0);
    for (int i = 0; i < 20 && !InsValid; i++) applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("lat3 InsValid arrives", 32'(InsValid), 32'd1);
    checkOutput("lat3 arrival cycle", cyc, 32'd7);
    checkOutput("lat3 InsPC", InsPC, 32'h100);
    checkOutput("lat3 InsWord", InsWord, 32'h5A5A_0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
